decode_regread: RTL and testbench

DECODE_REGREAD -- requirements
Module: decode_regread

---
 rtl/y86_pkg.sv | 57 +++++
 rtl/regfile_2r2w.sv | 42 ++++
 rtl/decode_regread.sv | 102 ++++++++++
 tb/tb_decode_regread.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - y86 icode/register constants and decode-stage operand selection
package y86_pkg;

  localparam int WIDTH_DEFAULT = 64;

  localparam logic [3:0] HALT   = 4'h0;
  localparam logic [3:0] NOP    = 4'h1;
  localparam logic [3:0] RRMOVQ = 4'h2;
  localparam logic [3:0] IRMOVQ = 4'h3;
  localparam logic [3:0] RMMOVQ = 4'h4;
  localparam logic [3:0] MRMOVQ = 4'h5;
  localparam logic [3:0] OPQ    = 4'h6;
  localparam logic [3:0] JXX    = 4'h7;
  localparam logic [3:0] CALL   = 4'h8;
  localparam logic [3:0] RET    = 4'h9;
  localparam logic [3:0] PUSHQ  = 4'hA;
  localparam logic [3:0] POPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RSP   = 4'h4;

  typedef struct packed {
    logic [3:0] src_a;
    logic [3:0] src_b;
    logic [3:0] dst_e;
    logic [3:0] dst_m;
  } regsel_t;

  // cmov (RRMOVQ) always names rB as dst_e; the condition is resolved downstream.
  function automatic regsel_t decode_regs(input logic [3:0] icode,
                                          input logic [3:0] ra,
                                          input logic [3:0] rb);
    regsel_t s;
    s = '{src_a: RNONE, src_b: RNONE, dst_e: RNONE, dst_m: RNONE};
    case (icode)
      RRMOVQ, RMMOVQ, OPQ, PUSHQ: s.src_a = ra;
      RET, POPQ:                  s.src_a = RSP;
      default:                    s.src_a = RNONE;
    endcase
    case (icode)
      RMMOVQ, MRMOVQ, OPQ:        s.src_b = rb;
      CALL, RET, PUSHQ, POPQ:     s.src_b = RSP;
      default:                    s.src_b = RNONE;
    endcase
    case (icode)
      RRMOVQ, IRMOVQ, OPQ:        s.dst_e = rb;
      CALL, RET, PUSHQ, POPQ:     s.dst_e = RSP;
      default:                    s.dst_e = RNONE;
    endcase
    case (icode)
      MRMOVQ, POPQ:               s.dst_m = ra;
      default:                    s.dst_m = RNONE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/regfile_2r2w.sv
// rtl/regfile_2r2w.sv - NREG x WIDTH register file, 2 comb read ports, 2 write ports (M wins)
module regfile_2r2w
  import y86_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int NREG  = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_e,
  input  logic [3:0]       dst_e,
  input  logic [WIDTH-1:0] val_e,
  input  logic             we_m,
  input  logic [3:0]       dst_m,
  input  logic [WIDTH-1:0] val_m,
  input  logic [3:0]       raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic [3:0]       raddr_b,
  output logic [WIDTH-1:0] rdata_b,
  input  logic [3:0]       dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  localparam logic [3:0] NREG4 = 4'(NREG);

  logic [WIDTH-1:0] regs [NREG];

  // The M write is issued last so it overrides E on a shared destination.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      if (we_e && dst_e < NREG4) regs[dst_e] <= val_e;
      if (we_m && dst_m < NREG4) regs[dst_m] <= val_m;
    end
  end

  assign rdata_a  = (raddr_a  < NREG4) ? regs[raddr_a]  : '0;
  assign rdata_b  = (raddr_b  < NREG4) ? regs[raddr_b]  : '0;
  assign dbg_data = (dbg_addr < NREG4) ? regs[dbg_addr] : '0;

endmodule

// File: rtl/decode_regread.sv
// rtl/decode_regread.sv - y86 decode stage: operand selection, register read with bypass, output register
module decode_regread
  import y86_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int NREG  = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       icode,
  input  logic [3:0]       rA,
  input  logic [3:0]       rB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] valA,
  output logic [WIDTH-1:0] valB,
  output logic [3:0]       icode_o,
  output logic [3:0]       dstE,
  output logic [3:0]       dstM,
  input  logic             wE_en,
  input  logic [3:0]       wE_dst,
  input  logic [WIDTH-1:0] wE_val,
  input  logic             wM_en,
  input  logic [3:0]       wM_dst,
  input  logic [WIDTH-1:0] wM_val,
  input  logic [3:0]       dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  localparam logic [3:0] NREG4 = 4'(NREG);

  regsel_t          sel;
  logic [WIDTH-1:0] rd_a;
  logic [WIDTH-1:0] rd_b;
  logic [WIDTH-1:0] val_a_next;
  logic [WIDTH-1:0] val_b_next;
  logic             accept;

  assign sel      = decode_regs(icode, rA, rB);
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  regfile_2r2w #(
    .WIDTH(WIDTH),
    .NREG (NREG)
  ) u_rf (
    .clk     (clk),
    .rst     (rst),
    .we_e    (wE_en),
    .dst_e   (wE_dst),
    .val_e   (wE_val),
    .we_m    (wM_en),
    .dst_m   (wM_dst),
    .val_m   (wM_val),
    .raddr_a (sel.src_a),
    .rdata_a (rd_a),
    .raddr_b (sel.src_b),
    .rdata_b (rd_b),
    .dbg_addr(dbg_addr),
    .dbg_data(dbg_data)
  );

  // Forward same-cycle write-back so the captured operand reflects it; M beats E.
  always_comb begin
    val_a_next = rd_a;
    if (sel.src_a < NREG4) begin
      if (wM_en && wM_dst == sel.src_a)      val_a_next = wM_val;
      else if (wE_en && wE_dst == sel.src_a) val_a_next = wE_val;
    end
  end

  always_comb begin
    val_b_next = rd_b;
    if (sel.src_b < NREG4) begin
      if (wM_en && wM_dst == sel.src_b)      val_b_next = wM_val;
      else if (wE_en && wE_dst == sel.src_b) val_b_next = wE_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      valA      <= '0;
      valB      <= '0;
      icode_o   <= 4'h0;
      dstE      <= RNONE;
      dstM      <= RNONE;
    end else if (accept) begin
      out_valid <= 1'b1;
      valA      <= val_a_next;
      valB      <= val_b_next;
      icode_o   <= icode;
      dstE      <= sel.dst_e;
      dstM      <= sel.dst_m;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_regread.sv
// tb/tb_decode_regread.sv - scoreboard bench for decode_regread
module tb_decode_regread;

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  ic;
    logic [3:0]  de;
    logic [3:0]  dm;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [3:0]  icode, rA, rB;
  logic        out_valid, out_ready;
  logic [63:0] valA, valB;
  logic [3:0]  icode_o, dstE, dstM;
  logic        wE_en, wM_en;
  logic [3:0]  wE_dst, wM_dst;
  logic [63:0] wE_val, wM_val;
  logic [3:0]  dbg_addr;
  logic [63:0] dbg_data;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   pops = 0;
  exp_t sb[$];
  int   pop_cyc[$];

  decode_regread #(.WIDTH(64), .NREG(15)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .icode(icode), .rA(rA), .rB(rB), .out_valid(out_valid), .out_ready(out_ready),
    .valA(valA), .valB(valB), .icode_o(icode_o), .dstE(dstE), .dstM(dstM),
    .wE_en(wE_en), .wE_dst(wE_dst), .wE_val(wE_val),
    .wM_en(wM_en), .wM_dst(wM_dst), .wM_val(wM_val),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic exp_t mk(logic [63:0] a, logic [63:0] b, logic [3:0] ic,
                              logic [3:0] de, logic [3:0] dm);
    exp_t e;
    e.a = a; e.b = b; e.ic = ic; e.de = de; e.dm = dm;
    return e;
  endfunction

  task automatic chk(string name, logic [63:0] got, logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Monitor: every transfer on the output side is matched against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result: got icode %h valA %h, expected no result", icode_o, valA);
        end else begin
          e = sb.pop_front();
          pop_cyc.push_back(cyc);
          pops++;
          if ({valA, valB, icode_o, dstE, dstM} !== e) begin
            errors++;
            $display("FAIL result: got valA=%h valB=%h ic=%h dstE=%h dstM=%h expected valA=%h valB=%h ic=%h dstE=%h dstM=%h",
                     valA, valB, icode_o, dstE, dstM, e.a, e.b, e.ic, e.de, e.dm);
          end
        end
      end
    end
  end

  // Presents one instruction (called just after posedge), returns just after the accepting posedge.
  task automatic issue(logic [3:0] ic, logic [3:0] ra, logic [3:0] rb, exp_t e);
    int n;
    in_valid = 1'b1; icode = ic; rA = ra; rB = rb;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got in_ready=0, expected 1 within 20 cycles");
    end else begin
      sb.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(logic e_en, logic [3:0] e_dst, logic [63:0] e_val,
                    logic m_en, logic [3:0] m_dst, logic [63:0] m_val);
    wE_en = e_en; wE_dst = e_dst; wE_val = e_val;
    wM_en = m_en; wM_dst = m_dst; wM_val = m_val;
  endtask

  initial begin
    int start;
    rst = 1'b1; in_valid = 1'b0; icode = 4'h1; rA = 4'hF; rB = 4'hF;
    out_ready = 1'b1; dbg_addr = 4'h0;
    wr(0, 4'hF, 0, 0, 4'hF, 0);
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_dstE", 64'(dstE), 64'hF);
    chk("reset_dstM", 64'(dstM), 64'hF);
    chk("reset_valA", valA, 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    tick();

    // opq after reset: all operands zero
    issue(4'h6, 4'h2, 4'h3, mk(0, 0, 4'h6, 4'h3, 4'hF));
    tick();

    // E and M both write R2 alongside an accept: M value forwarded and stored
    wr(1, 4'h2, 64'h11, 1, 4'h2, 64'h22);
    issue(4'h6, 4'h2, 4'hF, mk(64'h22, 0, 4'h6, 4'hF, 4'hF));
    wr(0, 4'hF, 0, 0, 4'hF, 0);
    dbg_addr = 4'h2;
    @(negedge clk);
    chk("dbg_r2_m_wins", dbg_data, 64'h22);
    tick();
    issue(4'h2, 4'h2, 4'h1, mk(64'h22, 0, 4'h2, 4'h1, 4'hF));

    // R4 = 0x100 then popq / irmovq / pushq / mrmovq
    wr(1, 4'h4, 64'h100, 0, 4'hF, 0);
    tick();
    wr(0, 4'hF, 0, 0, 4'hF, 0);
    issue(4'hB, 4'h5, 4'hF, mk(64'h100, 64'h100, 4'hB, 4'h4, 4'h5));
    issue(4'h3, 4'hF, 4'h6, mk(0, 0, 4'h3, 4'h6, 4'hF));
    issue(4'hA, 4'h2, 4'hF, mk(64'h22, 64'h100, 4'hA, 4'h4, 4'hF));
    issue(4'h5, 4'h7, 4'h4, mk(0, 64'h100, 4'h5, 4'hF, 4'h7));

    // E-only forwarding into srcB; write to F ignored
    wr(1, 4'h3, 64'h33, 1, 4'hF, 64'hDEAD);
    issue(4'h6, 4'h1, 4'h3, mk(0, 64'h33, 4'h6, 4'h3, 4'hF));
    wr(0, 4'hF, 0, 0, 4'hF, 0);
    dbg_addr = 4'hF;
    @(negedge clk);
    chk("dbg_rnone_zero", dbg_data, 64'd0);
    dbg_addr = 4'h3;
    #1 chk("dbg_r3", dbg_data, 64'h33);
    tick();

    // stall: result must hold while R2 is rewritten
    out_ready = 1'b0;
    issue(4'h2, 4'h2, 4'h1, mk(64'h22, 0, 4'h2, 4'h1, 4'hF));
    wr(1, 4'h2, 64'h99, 0, 4'hF, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_valA_held", valA, 64'h22);
      chk("stall_out_valid", 64'(out_valid), 64'd1);
      tick();
    end
    wr(0, 4'hF, 0, 0, 4'hF, 0);
    out_ready = 1'b1;
    issue(4'h6, 4'h2, 4'h3, mk(64'h99, 64'h33, 4'h6, 4'h3, 4'hF));
    tick();

    // reset with a held result and a pending write
    out_ready = 1'b0;
    issue(4'h6, 4'h2, 4'h3, mk(64'h99, 64'h33, 4'h6, 4'h3, 4'hF));
    wr(1, 4'h5, 64'h55, 1, 4'h6, 64'h66);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wr(0, 4'hF, 0, 0, 4'hF, 0);
    sb.delete();
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_dstE", 64'(dstE), 64'hF);
    for (int i = 0; i < 15; i++) begin
      dbg_addr = 4'(i);
      #1 chk($sformatf("rst_dbg_r%0d", i), dbg_data, 64'd0);
    end
    out_ready = 1'b1;
    tick();

    // load R0..R7 then stream 8 back-to-back
    for (int i = 0; i < 8; i += 2) begin
      wr(1, 4'(i), 64'h1000 + 64'(i), 1, 4'(i + 1), 64'h1000 + 64'(i + 1));
      tick();
    end
    wr(0, 4'hF, 0, 0, 4'hF, 0);
    start = pop_cyc.size();
    for (int i = 0; i < 8; i++)
      issue(4'h6, 4'(i), 4'(i + 1),
            mk(64'h1000 + 64'(i), (i == 7) ? 64'd0 : 64'h1000 + 64'(i + 1), 4'h6, 4'(i + 1), 4'hF));
    tick(); tick(); tick();
    chk("stream_count", 64'(pop_cyc.size() - start), 64'd8);
    for (int i = start + 1; i < pop_cyc.size(); i++)
      chk("stream_consecutive", 64'(pop_cyc[i] - pop_cyc[i - 1]), 64'd1);
    @(negedge clk);
    chk("final_out_valid", 64'(out_valid), 64'd0);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    chk("total_results", 64'(pops), 64'd18);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before 200000");
    $fatal(1);
  end

endmodule
